xtea_host: RTL

XTEA_HOST -- requirements
Module: xtea_host

---
 rtl/xtea_pkg.sv | 39 +++
 rtl/xtea_host.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xtea_pkg.sv
// ---------------------------------------------------------------------------
// xtea_pkg
//   Shared definitions for the XTEA register block and its bus host:
//   register address map, control/status/config bit positions and the
//   host FSM state encoding.
// ---------------------------------------------------------------------------
package xtea_pkg;

    // Register address map (32-bit registers, word addressed).
    localparam logic [7:0] ADDR_NAME0   = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0A;
    localparam logic [7:0] ADDR_ROUNDS  = 8'h0C;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;
    localparam logic [7:0] ADDR_RESULT1 = 8'h31;

    // Bit positions inside CTRL / STATUS / CONFIG.
    localparam int CTRL_NEXT_BIT     = 1;
    localparam int STATUS_READY_BIT  = 0;
    localparam int CONFIG_ENCDEC_BIT = 0;

    // Host FSM state encoding.
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_WR_KEY  = 4'd1;
    localparam state_t ST_WR_BLK  = 4'd2;
    localparam state_t ST_WR_CFG  = 4'd3;
    localparam state_t ST_WR_RND  = 4'd4;
    localparam state_t ST_WR_NEXT = 4'd5;
    localparam state_t ST_WAIT    = 4'd6;
    localparam state_t ST_POLL    = 4'd7;
    localparam state_t ST_RD0     = 4'd8;
    localparam state_t ST_RD1     = 4'd9;
    localparam state_t ST_DONE    = 4'd10;

endpackage

// File: rtl/xtea_host.sv
// ---------------------------------------------------------------------------
// xtea_host
//   Drives an XTEA register block over a simple single-cycle register bus:
//   loads key (when needed), block, config and rounds, kicks CTRL.next,
//   polls STATUS.ready and reads back the 64-bit result.
//
//   Ports
//     clk, reset_n          clock, async active-low reset
//     req_*                 request handshake + operands (sampled in IDLE)
//     rsp_*                 result handshake, result block, poll-timeout flag
//     cs/we/address/
//     write_data/read_data  register bus; read_data is combinational and
//                           valid in the same cycle as the read access
// ---------------------------------------------------------------------------
module xtea_host
    import xtea_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1024,
    parameter int NEXT_WAIT    = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [63:0]  req_block,
    input  logic         req_encdec,
    input  logic [5:0]   req_rounds,
    input  logic         req_rekey,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [63:0]  rsp_result,
    output logic         rsp_error,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data
);

    localparam int PW = $clog2(POLL_TIMEOUT + 1);
    // wait_cnt only needs to reach NEXT_WAIT-1; keep at least one bit.
    localparam int WW = (NEXT_WAIT > 1) ? $clog2(NEXT_WAIT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((NEXT_WAIT > 0) ? NEXT_WAIT - 1 : 0);

    state_t          state;
    logic [1:0]      sub;        // word index within WR_KEY / WR_BLK
    logic [WW-1:0]   wait_cnt;
    logic [PW-1:0]   poll_cnt;
    logic            key_loaded; // set only once all four key words are out
    logic [127:0]    key_r;
    logic [63:0]     blk_r;
    logic            encdec_r;
    logic [5:0]      rounds_r;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sub        <= '0;
            wait_cnt   <= '0;
            poll_cnt   <= '0;
            key_loaded <= 1'b0;
            key_r      <= '0;
            blk_r      <= '0;
            encdec_r   <= 1'b0;
            rounds_r   <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    key_r    <= req_key;
                    blk_r    <= req_block;
                    encdec_r <= req_encdec;
                    rounds_r <= req_rounds;
                    sub      <= '0;
                    // rekey only steers this decision, so it is used directly.
                    state    <= (req_rekey || !key_loaded) ? ST_WR_KEY : ST_WR_BLK;
                end
                ST_WR_KEY: begin
                    sub <= sub + 2'd1;  // wraps to 0 for WR_BLK
                    if (sub == 2'd3) begin
                        key_loaded <= 1'b1;
                        state      <= ST_WR_BLK;
                    end
                end
                ST_WR_BLK: begin
                    if (sub[0]) begin
                        sub   <= '0;
                        state <= ST_WR_CFG;
                    end else begin
                        sub <= sub + 2'd1;
                    end
                end
                ST_WR_CFG: state <= ST_WR_RND;
                ST_WR_RND: state <= ST_WR_NEXT;
                ST_WR_NEXT: begin
                    wait_cnt <= '0;
                    poll_cnt <= '0;
                    state    <= (NEXT_WAIT == 0) ? ST_POLL : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        poll_cnt <= '0;
                        state    <= ST_POLL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_POLL: begin
                    if (read_data[STATUS_READY_BIT]) begin
                        state <= ST_RD0;
                    end else begin
                        // Counter stops at POLL_TIMEOUT because we leave POLL.
                        poll_cnt <= poll_cnt + 1'b1;
                        if (poll_cnt == POLL_LAST) begin
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_RD0: begin
                    rsp_result[63:32] <= read_data;
                    rsp_error         <= 1'b0;
                    state             <= ST_RD1;
                end
                ST_RD1: begin
                    rsp_result[31:0] <= read_data;
                    state            <= ST_DONE;
                end
                ST_DONE: if (rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus signals decode straight from state so an async reset drops cs
    // in the same cycle.
    always_comb begin
        cs         = 1'b0;
        we         = 1'b0;
        address    = '0;
        write_data = '0;
        case (state)
            ST_WR_KEY: begin
                cs      = 1'b1;
                we      = 1'b1;
                address = ADDR_KEY0 + {6'b0, sub};
                case (sub)
                    2'd0:    write_data = key_r[127:96];
                    2'd1:    write_data = key_r[95:64];
                    2'd2:    write_data = key_r[63:32];
                    default: write_data = key_r[31:0];
                endcase
            end
            ST_WR_BLK: begin
                cs         = 1'b1;
                we         = 1'b1;
                address    = ADDR_BLOCK0 + {7'b0, sub[0]};
                write_data = sub[0] ? blk_r[31:0] : blk_r[63:32];
            end
            ST_WR_CFG: begin
                cs      = 1'b1;
                we      = 1'b1;
                address = ADDR_CONFIG;
                write_data[CONFIG_ENCDEC_BIT] = encdec_r;
            end
            ST_WR_RND: begin
                cs         = 1'b1;
                we         = 1'b1;
                address    = ADDR_ROUNDS;
                write_data = {26'b0, rounds_r};
            end
            ST_WR_NEXT: begin
                cs      = 1'b1;
                we      = 1'b1;
                address = ADDR_CTRL;
                write_data[CTRL_NEXT_BIT] = 1'b1;
            end
            ST_POLL: begin
                cs      = 1'b1;
                address = ADDR_STATUS;
            end
            ST_RD0: begin
                cs      = 1'b1;
                address = ADDR_RESULT0;
            end
            ST_RD1: begin
                cs      = 1'b1;
                address = ADDR_RESULT1;
            end
            default: ;
        endcase
    end

endmodule
